// File: rtl/rtlola_pkg.sv
// Shared types and width helpers for the event ingress queue.
package rtlola_pkg;

  localparam int unsigned NumInputs = 2;
  localparam int unsigned DataW     = 64;
  localparam int unsigned TsW       = 32;
  localparam int unsigned TagW      = 8;

  typedef struct packed {
    logic [NumInputs*DataW-1:0] data;
    logic [NumInputs-1:0]       new_mask;
    logic                       tick;
    logic [TsW-1:0]             ts;
    logic [TagW-1:0]            tag;
  } event_t;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int unsigned event_width(input int unsigned n, input int unsigned dw,
                                              input int unsigned tsw, input int unsigned tagw);
    return n * dw + n + 1 + tsw + tagw;
  endfunction

endpackage

// File: rtl/event_fifo.sv
// Circular buffer of packed event records with push/pop handshake and occupancy.
module event_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [Width-1:0]         data_i,
  output logic                     push_ok_o,
  output logic                     pop_ok_o,
  output logic [Width-1:0]         head_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  always_comb begin
    full_o    = (count_q == CntW'(Depth));
    empty_o   = (count_q == '0);
    pop_ok_o  = pop_i & ~empty_o;
    // A pop in the same cycle frees the slot a full queue needs.
    push_ok_o = push_i & (~full_o | pop_ok_o);
    head_o    = mem_q[rd_ptr_q];
    count_o   = count_q;
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_o) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop_ok_o) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({push_ok_o, pop_ok_o})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/event_ingress_queue.sv
// Bundles per-cycle input strobes and periodic ticks into timestamped, tagged events
// and queues them for the LLC; drops on overflow are counted.
module event_ingress_queue
  import rtlola_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = rtlola_pkg::NumInputs,
  parameter int unsigned DATA_W     = rtlola_pkg::DataW,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned TS_W       = rtlola_pkg::TsW,
  parameter int unsigned TAG_W      = rtlola_pkg::TagW,
  parameter int unsigned PERIOD     = 500
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [NUM_INPUTS*DATA_W-1:0] input_data,
  input  logic [NUM_INPUTS-1:0]        new_input,
  input  logic                         q_pop,
  output logic [NUM_INPUTS*DATA_W-1:0] head_data,
  output logic [NUM_INPUTS-1:0]        head_new,
  output logic                         head_tick,
  output logic [TS_W-1:0]              head_ts,
  output logic [TAG_W-1:0]             llc_tag,
  output logic                         q_push,
  output logic                         q_push_valid,
  output logic                         q_pop_valid,
  output logic                         q_empty,
  output logic                         q_full,
  output logic [$clog2(DEPTH):0]       q_count,
  output logic                         overflow,
  output logic [15:0]                  drop_count
);

  localparam int unsigned EvW   = event_width(NUM_INPUTS, DATA_W, TS_W, TAG_W);
  localparam int unsigned TickW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [TickW-1:0] TickLast = (PERIOD > 0) ? TickW'(PERIOD - 1) : '0;

  logic [TS_W-1:0]  ts_q, ts_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [TickW-1:0] tick_q, tick_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      drop_q, drop_d;

  logic             tick_due;
  logic             push_ok;
  logic [EvW-1:0]   ev_in, ev_head;

  always_comb begin
    tick_due = (PERIOD != 0) && (tick_q == TickLast);
    q_push   = en & ((|new_input) | tick_due);
    ev_in    = {input_data, new_input, tick_due, ts_q, tag_q};
  end

  event_fifo #(
    .Width (EvW),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i     (clk),
    .rst_i     (rst),
    .push_i    (q_push),
    .pop_i     (en & q_pop),
    .data_i    (ev_in),
    .push_ok_o (push_ok),
    .pop_ok_o  (q_pop_valid),
    .head_o    (ev_head),
    .count_o   (q_count),
    .full_o    (q_full),
    .empty_o   (q_empty)
  );

  always_comb begin
    ts_d       = ts_q;
    tag_d      = tag_q;
    tick_d     = tick_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (en) begin
      ts_d = ts_q + TS_W'(1);
      if (PERIOD != 0) tick_d = tick_due ? '0 : tick_q + TickW'(1);
      if (push_ok) tag_d = tag_q + TAG_W'(1);
      if (q_push && !push_ok) begin
        overflow_d = 1'b1;
        if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q       <= '0;
      tag_q      <= '0;
      tick_q     <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      ts_q       <= ts_d;
      tag_q      <= tag_d;
      tick_q     <= tick_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  always_comb begin
    q_push_valid = push_ok;
    overflow     = overflow_q;
    drop_count   = drop_q;
    head_data    = ev_head[EvW-1 -: NUM_INPUTS*DATA_W];
    head_new     = ev_head[TS_W+TAG_W+1 +: NUM_INPUTS];
    head_tick    = ev_head[TS_W+TAG_W];
    head_ts      = ev_head[TAG_W +: TS_W];
    llc_tag      = ev_head[TAG_W-1:0];
  end

endmodule
